// File: rtl/inter_core_fifo_arbiter_pkg.sv
// Shared types, defaults and error-cause indices for the inter-core FIFO port arbiter.
package inter_core_fifo_pkg;

    localparam int DefNumReq    = 8;
    localparam int DefAddrWidth = 32;
    localparam int DefDataWidth = 32;
    localparam int IdxWidth     = $clog2(DefNumReq);

    typedef logic [IdxWidth-1:0] idx_t;

    typedef enum logic {
        Idle,
        Locked
    } state_e;

    localparam int ErrSpurious  = 0;
    localparam int ErrDrop      = 1;
    localparam int NumErrCauses = 2;

    // Next core index after v, wrapping at n (n need not be a power of two).
    function automatic idx_t incWrap(idx_t v, int n);
        return (int'(v) == n - 1) ? '0 : idx_t'(v + idx_t'(1));
    endfunction

endpackage

// File: rtl/inter_core_fifo_arbiter_if.sv
// Request/response bus of NumPorts ports: the core side uses NumPorts cores, the FIFO side a single port.
interface inter_core_fifo_arbiter_if #(
    parameter int NumPorts  = 1,
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
);

    logic [NumPorts-1:0]                req;
    logic [NumPorts-1:0][AddrWidth-1:0] add;
    logic [NumPorts-1:0]                wen;
    logic [NumPorts-1:0][DataWidth-1:0] wdata;
    logic [NumPorts-1:0]                gnt;
    logic [NumPorts-1:0]                r_valid;
    logic [DataWidth-1:0]               r_rdata;

    modport master (
        output req, add, wen, wdata,
        input  gnt, r_valid, r_rdata
    );

    modport slave (
        input  req, add, wen, wdata,
        output gnt, r_valid, r_rdata
    );

endinterface

// File: rtl/inter_core_fifo_arbiter_rr_pick.sv
// Round-robin pick: first set request at or after ptr_i, wrapping around the core count.
module inter_core_fifo_rr_pick
    import inter_core_fifo_pkg::*;
#(
    parameter int NumReq = DefNumReq
) (
    input  logic [NumReq-1:0] req_i,
    input  idx_t              ptr_i,
    output idx_t              winner_o,
    output logic              valid_o
);

    int   cand;
    idx_t candIdx;

    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        cand     = 0;
        candIdx  = '0;
        for (int k = 0; k < NumReq; k++) begin
            cand = int'(ptr_i) + k;
            if (cand >= NumReq) begin
                cand = cand - NumReq;
            end
            candIdx = idx_t'(cand);
            if (!valid_o && req_i[candIdx]) begin
                valid_o  = 1'b1;
                winner_o = candIdx;
            end
        end
    end

endmodule

// File: rtl/inter_core_fifo_arbiter.sv
// Shares one inter-core FIFO port among NumReq cores: locked round-robin arbitration, response routed to the granted core.
module inter_core_fifo_arbiter
    import inter_core_fifo_pkg::*;
#(
    parameter int NumReq    = DefNumReq,
    parameter int AddrWidth = DefAddrWidth,
    parameter int DataWidth = DefDataWidth
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    inter_core_fifo_arbiter_if.slave   core,
    inter_core_fifo_arbiter_if.master  mst,
    output logic                       err_o
);

    state_e state_q, state_d;
    idx_t   rrPtr_q, rrPtr_d;
    idx_t   lockIdx_q, lockIdx_d;
    idx_t   rspIdx_q, rspIdx_d;
    logic   rspPend_q, rspPend_d;
    logic   err_q, err_d;

    idx_t                  pickIdx, winner;
    logic                  pickValid, mstReq, handshake;
    logic [AddrWidth-1:0]  mstAdd;
    logic [DataWidth-1:0]  mstWdata;
    logic                  mstWen;
    logic [NumErrCauses-1:0] errEvent;

    inter_core_fifo_rr_pick #(
        .NumReq (NumReq)
    ) uPick (
        .req_i    (core.req),
        .ptr_i    (rrPtr_q),
        .winner_o (pickIdx),
        .valid_o  (pickValid)
    );

    // Outputs are gated by rst_ni so the port is quiet while reset is held.
    always_comb begin
        winner    = (state_q == Locked) ? lockIdx_q : pickIdx;
        mstReq    = rst_ni & ((state_q == Locked) ? core.req[lockIdx_q] : pickValid);
        handshake = mstReq & mst.gnt[0];
        mstAdd    = mstReq ? core.add[winner]   : '0;
        mstWen    = mstReq ? core.wen[winner]   : 1'b0;
        mstWdata  = mstReq ? core.wdata[winner] : '0;
        core.gnt  = '0;
        if (handshake) begin
            core.gnt[winner] = 1'b1;
        end
        core.r_valid = '0;
        if (mst.r_valid[0] & rspPend_q) begin
            core.r_valid[rspIdx_q] = 1'b1;
        end
    end

    assign mst.req[0]   = mstReq;
    assign mst.add[0]   = mstAdd;
    assign mst.wen[0]   = mstWen;
    assign mst.wdata[0] = mstWdata;
    assign core.r_rdata = mst.r_rdata;
    assign err_o        = err_q;

    always_comb begin
        state_d   = state_q;
        rrPtr_d   = rrPtr_q;
        lockIdx_d = lockIdx_q;
        rspPend_d = handshake;
        rspIdx_d  = winner;
        errEvent  = '0;
        errEvent[ErrSpurious] = mst.r_valid[0] & ~rspPend_q;
        case (state_q)
            Idle: begin
                if (handshake) begin
                    rrPtr_d = incWrap(winner, NumReq);
                end else if (mstReq) begin
                    state_d   = Locked;
                    lockIdx_d = winner;
                end
            end
            Locked: begin
                // A locked core must hold its request until granted.
                if (handshake) begin
                    state_d = Idle;
                    rrPtr_d = incWrap(lockIdx_q, NumReq);
                end else if (!core.req[lockIdx_q]) begin
                    errEvent[ErrDrop] = 1'b1;
                    state_d           = Idle;
                end
            end
            default: state_d = Idle;
        endcase
        err_d = err_q | (|errEvent);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= Idle;
            rrPtr_q   <= '0;
            lockIdx_q <= '0;
            rspPend_q <= 1'b0;
            rspIdx_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rrPtr_q   <= rrPtr_d;
            lockIdx_q <= lockIdx_d;
            rspPend_q <= rspPend_d;
            rspIdx_q  <= rspIdx_d;
            err_q     <= err_d;
        end
    end

endmodule
